mult_job_sequencer: RTL and testbench

Upstream job-feeding stage for the add-shift multiplier: accepts operand pairs on a valid/ready input, buffers them in a small FIFO, and presents one job at a time to the multiplier. It drives the multiplier's operand words and one-cycle start, waits for the multiplier to return to ready, captures the product, and offers it on a valid/ready output. It is the only source of start for the multiplier controller and datapath.

---
 rtl/mult_seq_pkg.sv | 22 ++
 rtl/mult_job_fifo.sv | 74 +++++++
 rtl/mult_job_sequencer.sv | 148 ++++++++++++++
 tb/tb_mult_job_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// Shared types and defaults for the multiplier job sequencer.
// Optional feature macro used by the top: MULT_SEQ_ZERO_BYPASS_EN.
package mult_seq_pkg;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_DEPTH  = 4;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    // One multiplication job at the default operand width.
    typedef struct packed {
        logic [DEF_WORD_W-1:0] multiplicand;
        logic [DEF_WORD_W-1:0] multiplier;
    } job_t;

endpackage

// File: rtl/mult_job_fifo.sv
// Synchronous FIFO holding pending jobs for the sequencer.
// A push into a full FIFO and a pop from an empty one are ignored.
// Pointers wrap naturally.
module mult_job_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [DATA_W-1:0]      wr_data_i,
    output logic [DATA_W-1:0]      rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while the entry is not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/mult_job_sequencer.sv
// Job feeder for the add-shift multiplier: buffers operand pairs, issues
// one job at a time with a single-cycle start, captures the product when
// the controller returns to ready, and offers it on a valid/ready output.
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high; valid never depends on ready, and in_ready depends only on
// the FIFO full flag.
// Optional feature: define MULT_SEQ_ZERO_BYPASS_EN to skip the multiplier
// for jobs with a zero operand (result 0 goes straight to the output).
module mult_job_sequencer
    import mult_seq_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_multiplicand,
    input  logic [WORD_W-1:0]   in_multiplier,
    output logic                mul_start,
    output logic [WORD_W-1:0]   mul_multiplicand,
    output logic [WORD_W-1:0]   mul_multiplier,
    input  logic                mul_ready,
    input  logic [2*WORD_W-1:0] mul_product,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*WORD_W-1:0] out_product,
    output logic                busy,
    output logic [15:0]         jobs_done
);

    state_e                  state_q, state_d;
    logic [WORD_W-1:0]       mcand_q, mplier_q;
    logic [2*WORD_W-1:0]     out_product_q;
    logic [15:0]             jobs_done_q;

    logic                    fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [2*WORD_W-1:0]     fifo_head;
    logic [WORD_W-1:0]       head_mcand, head_mplier;

    logic                    pop_job, capture, deliver;

    assign head_mcand  = fifo_head[2*WORD_W-1:WORD_W];
    assign head_mplier = fifo_head[WORD_W-1:0];

    mult_job_fifo #(
        .DATA_W (2*WORD_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (in_valid && in_ready),
        .pop_i     (pop_job),
        .wr_data_i ({in_multiplicand, in_multiplier}),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign in_ready         = !fifo_full;
    assign mul_multiplicand = mcand_q;
    assign mul_multiplier   = mplier_q;
    assign out_product      = out_product_q;
    assign jobs_done        = jobs_done_q;
    assign busy             = (state_q != S_IDLE) || (fifo_count != '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_job) begin
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                    if ((head_mcand == '0) || (head_mplier == '0)) begin
                        state_d = S_OUT;
                    end else begin
                        state_d = S_ISSUE;
                    end
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            S_ISSUE: if (mul_ready) state_d = S_WAIT;
            S_WAIT:  if (capture)   state_d = S_OUT;
            S_OUT:   if (deliver)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and strobe decode from the current state.
    always_comb begin
        mul_start = 1'b0;
        out_valid = 1'b0;
        pop_job   = 1'b0;
        capture   = 1'b0;
        deliver   = 1'b0;
        case (state_q)
            S_IDLE:  pop_job = !fifo_empty && mul_ready;
            S_ISSUE: mul_start = 1'b1;
            S_WAIT:  capture = mul_ready;
            S_OUT: begin
                out_valid = 1'b1;
                deliver   = out_ready;
            end
            default: ;
        endcase
    end

    // Operand, result and delivery-counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q       <= '0;
            mplier_q      <= '0;
            out_product_q <= '0;
            jobs_done_q   <= '0;
        end else begin
            if (pop_job) begin
                mcand_q  <= head_mcand;
                mplier_q <= head_mplier;
`ifdef MULT_SEQ_ZERO_BYPASS_EN
                if ((head_mcand == '0) || (head_mplier == '0)) begin
                    out_product_q <= '0;
                end
`endif
            end
            if (capture) begin
                out_product_q <= mul_product;
            end
            if (deliver) begin
                jobs_done_q <= jobs_done_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Bench for mult_job_sequencer with a behavioural add-shift multiplier.
// Honours MULT_SEQ_ZERO_BYPASS_EN when the design is built with it.
module tb_mult_job_sequencer;
  import mult_seq_pkg::*;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_multiplicand = '0;
  logic [W-1:0]  in_multiplier = '0;
  logic          mul_start;
  logic [W-1:0]  mul_multiplicand;
  logic [W-1:0]  mul_multiplier;
  logic          m_ready;
  logic [2*W-1:0] m_product;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] out_product;
  logic          busy;
  logic [15:0]   jobs_done;

  int n_checks = 0;
  int n_fails = 0;
  int start_cnt = 0;
  int exp_done = 0;
  int m_cnt;
  logic [2*W-1:0] exp_q[$];

  mult_job_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_multiplicand  (in_multiplicand),
    .in_multiplier    (in_multiplier),
    .mul_start        (mul_start),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_ready        (m_ready),
    .mul_product      (m_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .busy             (busy),
    .jobs_done        (jobs_done)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural multiplier: zero operand flushes (stays ready, product 0),
  // otherwise busy for W cycles then product and ready
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ready <= 1'b1;
      m_product <= '0;
      m_cnt <= 0;
    end else if (m_ready) begin
      if (mul_start) begin
        m_product <= '0;
        if (mul_multiplicand != '0 && mul_multiplier != '0) begin
          m_ready <= 1'b0;
          m_cnt <= W;
        end
      end
    end else begin
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        m_product <= mul_multiplicand * mul_multiplier;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  // start pulse counter
  always @(negedge clk) begin
    if (!reset && mul_start) start_cnt++;
  end

  // scoreboard: compare each delivered result against the expected queue
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      logic [2*W-1:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      assert (out_product === e) else begin
        n_fails++;
        $error("FAIL result: observed=0x%0h expected=0x%0h", out_product, e);
      end
      exp_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // offer a job until accepted (bounded); expected product queued on accept
  task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] b);
    logic ok;
    logic [2*W-1:0] p;
    int guard;
    guard = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_multiplicand = a;
    in_multiplier = b;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("push_accepted", ok, 1);
    if (ok) begin
      p = a * b;
      exp_q.push_back(p);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int guard;
    guard = 0;
    while (!out_valid && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || out_valid) && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("wait_idle", busy, 0);
  endtask

  job_t jobs[6];

  initial begin
    int s0;
    int guard;

    // reset and reset values
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_mcand", mul_multiplicand, 0);
    chk("rst_mplier", mul_multiplier, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_product", out_product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single job 13 x 11
    s0 = start_cnt;
    push_job(8'd13, 8'd11);
    wait_idle();
    chk("single_starts", start_cnt - s0, 1);
    chk("single_jobs_done", jobs_done, 1);
    chk("single_out_product", out_product, 16'h008F);

    // 255 x 255
    push_job(8'd255, 8'd255);
    wait_idle();
    chk("max_out_product", out_product, 16'hFE01);
    chk("max_jobs_done", jobs_done, 2);

    // zero operand
    s0 = start_cnt;
    push_job(8'd0, 8'd77);
`ifdef MULT_SEQ_ZERO_BYPASS_EN
    @(posedge clk);
    #1;
    chk("bypass_out_valid", out_valid, 1);
    wait_idle();
    chk("zero_starts", start_cnt - s0, 0);
`else
    wait_idle();
    chk("zero_starts", start_cnt - s0, 1);
`endif
    chk("zero_out_product", out_product, 0);

    // backpressure: job 1 parks in S_OUT, jobs 2-5 fill the FIFO, job 6 refused
    for (int i = 0; i < 6; i++) begin
      jobs[i].multiplicand = W'($urandom_range(1, 255));
      jobs[i].multiplier = W'($urandom_range(1, 255));
    end
    out_ready = 1'b0;
    push_job(jobs[0].multiplicand, jobs[0].multiplier);
    wait_out_valid();
    for (int i = 1; i < 5; i++) push_job(jobs[i].multiplicand, jobs[i].multiplier);
    chk("full_count", dut.u_fifo.count_o, 4);
    in_valid = 1'b1;
    in_multiplicand = jobs[5].multiplicand;
    in_multiplier = jobs[5].multiplier;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", in_ready, 0);
      chk("full_out_valid", out_valid, 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_job(jobs[5].multiplicand, jobs[5].multiplier);
    wait_idle();
    chk("drain_jobs_done", jobs_done, 9);
    chk("drain_queue_empty", exp_q.size(), 0);

    // simultaneous push and pop at count 2
    out_ready = 1'b0;
    push_job(8'd7, 8'd9);
    wait_out_valid();
    push_job(8'd21, 8'd3);
    push_job(8'd100, 8'd2);
    chk("sim_count_before", dut.u_fifo.count_o, 2);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_multiplicand = 8'd17;
    in_multiplier = 8'd19;
    chk("sim_in_ready", in_ready, 1);
    chk("sim_idle_pop_ready", busy, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(16'd323);
    chk("sim_count_after", dut.u_fifo.count_o, 2);
    wait_idle();
    chk("sim_jobs_done", jobs_done, 13);

    // reset while waiting on the multiplier
    push_job(8'd200, 8'd200);
    guard = 0;
    while (dut.state_q != S_WAIT && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("reached_wait", (dut.state_q == S_WAIT), 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    exp_done = 0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_mul_start", mul_start, 0);
    chk("mid_rst_mcand", mul_multiplicand, 0);
    chk("mid_rst_mplier", mul_multiplier, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_product", out_product, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_jobs_done", jobs_done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    push_job(8'd3, 8'd5);
    wait_idle();
    chk("post_rst_out_product", out_product, 16'h000F);
    chk("post_rst_jobs_done", jobs_done, 1);
    chk("post_rst_scoreboard_done", exp_done, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
